residual_assembler: RTL and testbench

- Sits directly downstream of the Rice residual decoder and consumes its per-sample quotient (MSB) / remainder (LSB) pairs.
- Rebuilds the folded unsigned value u = (MSB << k) | LSB, unfolds it to a signed residual, and tags the final residual of each Rice partition.
- Buffers results in a small FIFO with valid/ready output and a ready back-pressure signal toward the decoder.
- Feeds the LPC/fixed predictor stage.

---
 rtl/flac_pkg.sv | 22 ++
 rtl/res_fifo.sv | 78 +++++++
 rtl/residual_assembler.sv | 127 ++++++++++++
 tb/tb_residual_assembler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/flac_pkg.sv
// -----------------------------------------------------------------------------
// flac_pkg
// Shared widths and helpers for the FLAC residual path.
//   RICE_K_W : width of the Rice parameter k
//   MSB_W    : width of the Rice quotient from the decoder
//   LSB_W    : width of the Rice remainder from the decoder
//   U_W      : width of the folded unsigned value u
//   zigzag_unfold(u) : maps folded u back to its two's-complement residual
// -----------------------------------------------------------------------------
package flac_pkg;

  localparam int RICE_K_W = 4;
  localparam int MSB_W    = 16;
  localparam int LSB_W    = 16;
  localparam int U_W      = 32;

  // (u >> 1) ^ -(u & 1): the mask is all ones when u is odd, all zeros otherwise.
  function automatic logic [U_W-1:0] zigzag_unfold(input logic [U_W-1:0] u);
    return (u >> 1) ^ {U_W{u[0]}};
  endfunction

endpackage

// File: rtl/res_fifo.sv
// -----------------------------------------------------------------------------
// res_fifo
// Generic synchronous FIFO with separate occupancy counter.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset (empties the FIFO)
//   push_i       : write push_data_i (caller must not push when full without pop)
//   push_data_i  : write data
//   pop_i        : remove head (ignored when empty)
//   pop_data_o   : head entry, meaningful only when empty_o = 0
//   full_o       : count == DEPTH
//   empty_o      : count == 0
//   count_o      : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module res_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (count_q == CNT_W'(0));
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    do_push  = push_i;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/residual_assembler.sv
// -----------------------------------------------------------------------------
// residual_assembler
// Rebuilds u = (MSB << k) | LSB from Rice decoder output, unfolds it to a
// signed residual, tags the last residual of each partition and buffers the
// results for the predictor stage.
//   iClk, iRst     : clock, synchronous active-high reset
//   iPartStart     : strobe, loads iPartSamples / iRiceParam
//   iPartSamples   : residual count of the new partition
//   iRiceParam     : Rice parameter k
//   iValid         : strobe per decoded residual (iMSB / iLSB)
//   oReady         : a residual can be accepted this cycle
//   oValid/iReady  : output handshake, oRes/oLast describe the FIFO head
//   oDropErr       : sticky, set when a residual was discarded
// -----------------------------------------------------------------------------
module residual_assembler
  import flac_pkg::*;
#(
  parameter int RES_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iPartStart,
  input  logic [15:0]         iPartSamples,
  input  logic [3:0]          iRiceParam,
  input  logic                iValid,
  input  logic [15:0]         iMSB,
  input  logic [15:0]         iLSB,
  output logic                oReady,
  output logic                oValid,
  input  logic                iReady,
  output logic [RES_W-1:0]    oRes,
  output logic                oLast,
  output logic                oDropErr
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  // Partition state: remaining == 0 is IDLE, anything else ACTIVE.
  logic [15:0]         rem_q, rem_d;
  logic [RICE_K_W-1:0] k_q, k_d;
  logic [15:0]         rem_cur;
  logic [RICE_K_W-1:0] k_cur;
  logic                accept;
  logic                drop;
  logic                last_tag;
  logic [U_W-1:0]      u_d;

  logic                s1_valid_q, s1_last_q;
  logic [U_W-1:0]      s1_u_q;
  logic                s2_valid_q, s2_last_q;
  logic [RES_W-1:0]    s2_res_q;
  logic                drop_q;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [RES_W:0]      fifo_head;
  logic [OCC_W-1:0]    occupancy;

  // Everything already committed to the FIFO, including in-flight stages, so
  // an accepted residual always has a slot reserved when it reaches E2.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q);
  assign oReady    = (occupancy <= OCC_W'(FIFO_DEPTH - 1));

  // Accept / drop decision; a same-cycle start is applied before accepting.
  always_comb begin
    rem_cur  = iPartStart ? iPartSamples : rem_q;
    k_cur    = iPartStart ? iRiceParam   : k_q;
    accept   = iValid && (rem_cur != 16'd0) && oReady;
    drop     = iValid && !accept;
    last_tag = (rem_cur == 16'd1);
    rem_d    = accept ? rem_cur - 16'd1 : rem_cur;
    k_d      = k_cur;
    u_d      = (U_W'(iMSB) << k_cur) | U_W'(iLSB);
  end

  // Partition counter, two pipeline stages and sticky drop flag.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rem_q      <= 16'd0;
      k_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_u_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_res_q   <= '0;
      drop_q     <= 1'b0;
    end else begin
      rem_q      <= rem_d;
      k_q        <= k_d;
      s1_valid_q <= accept;
      s1_last_q  <= accept && last_tag;
      s1_u_q     <= u_d;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_res_q   <= RES_W'($signed(zigzag_unfold(s1_u_q)));
      drop_q     <= drop_q | drop;
    end
  end

  // Occupancy accounting keeps the FIFO from filling; the full term is a guard.
  assign fifo_pop  = oValid && iReady;
  assign fifo_push = s2_valid_q && (!fifo_full || fifo_pop);

  res_fifo #(
    .WIDTH (RES_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (iClk),
    .rst_i       (iRst),
    .push_i      (fifo_push),
    .push_data_i ({s2_last_q, s2_res_q}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign oValid   = !fifo_empty;
  assign oLast    = fifo_head[RES_W];
  assign oRes     = fifo_head[RES_W-1:0];
  assign oDropErr = drop_q;

endmodule

// File: tb/tb_residual_assembler.sv
module tb_residual_assembler;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iPartStart;
  logic [15:0] iPartSamples;
  logic [3:0]  iRiceParam;
  logic        iValid;
  logic [15:0] iMSB, iLSB;
  logic        oReady, oValid, iReady;
  logic [31:0] oRes;
  logic        oLast, oDropErr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        last;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  always #5 iClk = ~iClk;

  residual_assembler #(.RES_W(32), .FIFO_DEPTH(8)) dut (
    .iClk(iClk), .iRst(iRst), .iPartStart(iPartStart), .iPartSamples(iPartSamples),
    .iRiceParam(iRiceParam), .iValid(iValid), .iMSB(iMSB), .iLSB(iLSB),
    .oReady(oReady), .oValid(oValid), .iReady(iReady), .oRes(oRes),
    .oLast(oLast), .oDropErr(oDropErr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Independent reference unfold: even u -> u/2, odd u -> -(u+1)/2.
  function automatic logic [31:0] ref_unfold(input logic [31:0] u);
    if (u[0]) return 32'd0 - (u >> 1) - 32'd1;
    else      return u >> 1;
  endfunction

  // Scoreboard monitor: compare every popped head against the queue.
  always @(negedge iClk) begin
    if (!iRst && oValid && iReady) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none", oRes);
      end else begin
        mon_e = q.pop_front();
        check("res", oRes, mon_e.res);
        check("last", {31'd0, oLast}, {31'd0, mon_e.last});
      end
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic start(input logic [15:0] n, input logic [3:0] k);
    iPartStart = 1'b1; iPartSamples = n; iRiceParam = k;
    tick();
    iPartStart = 1'b0;
  endtask

  task automatic send(input logic [15:0] msb, input logic [15:0] lsb,
                      input logic [31:0] res, input logic last);
    exp_t e;
    e.res = res; e.last = last;
    q.push_back(e);
    iValid = 1'b1; iMSB = msb; iLSB = lsb;
    tick();
    iValid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check({name, "_drained"}, q.size(), 32'd0);
    tick();
    check({name, "_empty"}, {31'd0, oValid}, 32'd0);
  endtask

  int sent;
  int budget;

  initial begin
    iRst = 1'b1; iPartStart = 1'b0; iPartSamples = 16'd0; iRiceParam = 4'd0;
    iValid = 1'b0; iMSB = 16'd0; iLSB = 16'd0; iReady = 1'b0;
    tick(); tick();
    iRst = 1'b0;
    check("rst_valid", {31'd0, oValid}, 32'd0);
    check("rst_ready", {31'd0, oReady}, 32'd1);
    check("rst_drop", {31'd0, oDropErr}, 32'd0);

    // Basic unfold, k = 2, with latency check.
    iReady = 1'b1;
    start(16'd4, 4'd2);
    send(16'd3, 16'd1, -32'sd7, 1'b0);
    check("lat_e0", {31'd0, oValid}, 32'd0);
    send(16'd0, 16'd0, 32'd0, 1'b0);
    check("lat_e1", {31'd0, oValid}, 32'd0);
    send(16'd0, 16'd1, -32'sd1, 1'b0);
    check("lat_e2", {31'd0, oValid}, 32'd1);
    send(16'd1, 16'd2, 32'd3, 1'b1);
    drain("basic");

    // k = 0 and k = 15 extremes.
    start(16'd1, 4'd0);
    send(16'd4, 16'd0, 32'd2, 1'b1);
    start(16'd1, 4'd15);
    send(16'hFFFF, 16'h7FFF, 32'hC000_0000, 1'b1);
    drain("kext");

    // Same-cycle start and accept.
    iPartStart = 1'b1; iPartSamples = 16'd1; iRiceParam = 4'd1;
    send(16'd1, 16'd0, 32'd1, 1'b1);
    iPartStart = 1'b0;
    drain("same_cycle");
    check("same_nodrop", {31'd0, oDropErr}, 32'd0);

    // Back in IDLE: a residual is dropped, nothing emerges.
    iValid = 1'b1; iMSB = 16'd5; iLSB = 16'd0;
    tick();
    iValid = 1'b0;
    repeat (5) tick();
    check("idle_drop", {31'd0, oDropErr}, 32'd1);
    check("idle_nowrite", {31'd0, oValid}, 32'd0);

    // Back-pressure: 20 residuals, k = 3, consumer stalled first.
    iRst = 1'b1; tick(); iRst = 1'b0;
    check("bp_drop_clr", {31'd0, oDropErr}, 32'd0);
    iReady = 1'b0;
    start(16'd20, 4'd3);
    sent = 0;
    repeat (20) begin
      if (oReady && sent < 20) begin
        send(16'(sent), 16'(sent % 8), ref_unfold(32'(sent * 8 + sent % 8)), sent == 19);
        sent++;
      end else begin
        tick();
      end
    end
    check("bp_stored", 32'(sent), 32'd8);
    check("bp_ready_low", {31'd0, oReady}, 32'd0);
    check("bp_head_valid", {31'd0, oValid}, 32'd1);
    iReady = 1'b1;
    budget = 0;
    while (sent < 20 && budget < 200) begin
      if (oReady) begin
        send(16'(sent), 16'(sent % 8), ref_unfold(32'(sent * 8 + sent % 8)), sent == 19);
        sent++;
      end else begin
        tick();
      end
      budget++;
    end
    check("bp_all_sent", 32'(sent), 32'd20);
    drain("bp");
    check("bp_nodrop", {31'd0, oDropErr}, 32'd0);

    // Forced drop while oReady = 0.
    iReady = 1'b0;
    start(16'd10, 4'd0);
    for (int j = 0; j < 8; j++) begin
      send(16'(j + 1), 16'd0, ref_unfold(32'(j + 1)), 1'b0);
    end
    check("fd_ready_low", {31'd0, oReady}, 32'd0);
    iValid = 1'b1; iMSB = 16'd99; iLSB = 16'd0;
    tick();
    iValid = 1'b0;
    check("fd_drop", {31'd0, oDropErr}, 32'd1);
    iReady = 1'b1;
    drain("fd");
    check("fd_sticky", {31'd0, oDropErr}, 32'd1);

    // Mid-operation reset: 5 buffered, 2 in flight.
    iReady = 1'b0;
    start(16'd7, 4'd0);
    for (int j = 0; j < 7; j++) begin
      send(16'(j + 10), 16'd0, ref_unfold(32'(j + 10)), j == 6);
    end
    iRst = 1'b1;
    q.delete();
    tick();
    iRst = 1'b0;
    check("mr_valid", {31'd0, oValid}, 32'd0);
    check("mr_ready", {31'd0, oReady}, 32'd1);
    check("mr_drop", {31'd0, oDropErr}, 32'd0);
    iReady = 1'b1;
    iValid = 1'b1; iMSB = 16'd7; iLSB = 16'd0;
    repeat (5) tick();
    iValid = 1'b0;
    repeat (4) tick();
    check("mr_ignored", {31'd0, oValid}, 32'd0);
    start(16'd1, 4'd0);
    send(16'd6, 16'd0, 32'd3, 1'b1);
    drain("mr_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
